// File: rtl/fp_norm_pkg.sv
// Shared definitions for the mantissa normalization path.
//
// Contents:
//   MANT_W_DEF / EXP_W_DEF : default mantissa and exponent widths
//   K_W                    : width of a shift-stage size
//   NUM_STEPS / STEP_K     : binary-search shift stages, largest first
//   state_t                : sequencer state encoding
//   step_k()               : maps a step index to its shift amount
package fp_norm_pkg;

  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF  = 8;
  localparam int K_W        = 5;
  localparam int NUM_STEPS  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Stages 16+8+4+2+1 can close any gap up to 31 leading zeros,
  // which is why mantissas up to 32 bits are covered.
  localparam logic [K_W-1:0] STEP_K [NUM_STEPS] = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

  // Indices past the last stage return 0 so the caller sees a no-op shift.
  function automatic logic [K_W-1:0] step_k(input logic [2:0] s);
    logic [K_W-1:0] k;
    k = '0;
    if (int'(s) < NUM_STEPS) begin
      k = STEP_K[s];
    end
    return k;
  endfunction

endpackage

// File: rtl/norm_step.sv
// One binary-search normalization stage (purely combinational).
//
// Ports:
//   mant         in   current mantissa
//   exp_val      in   current biased exponent
//   k            in   stage shift amount
//   shifted_mant out  mant << k when the stage fires, else mant
//   shifted_exp  out  exp_val - k when the stage fires, else exp_val
//   took_shift   out  stage fired
//
// The stage fires only if the top k bits are zero and the exponent can
// absorb the shift without dropping below 1; anything more would push the
// result below the smallest normal exponent, so it stays denormal instead.
module norm_step
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic [MANT_W-1:0] mant,
  input  logic [EXP_W-1:0]  exp_val,
  input  logic [K_W-1:0]    k,
  output logic [MANT_W-1:0] shifted_mant,
  output logic [EXP_W-1:0]  shifted_exp,
  output logic              took_shift
);

  logic [MANT_W-1:0] top_mask;
  logic              top_zero;
  logic              exp_ok;

  always_comb begin
    top_mask = ~({MANT_W{1'b1}} >> k);
    top_zero = ((mant & top_mask) == '0);
    // One extra bit so k+1 can never wrap against a small exponent.
    exp_ok   = ({1'b0, exp_val} >= ((EXP_W+1)'(k) + (EXP_W+1)'(1)));
    took_shift   = top_zero && exp_ok;
    shifted_mant = mant;
    shifted_exp  = exp_val;
    if (took_shift) begin
      shifted_mant = mant << k;
      shifted_exp  = exp_val - EXP_W'(k);
    end
  end

endmodule

// File: rtl/mant_norm_seq.sv
// Multi-cycle mantissa normalization sequencer.
//
// Ports:
//   clk, rst    clock (rising edge) and synchronous active-high reset
//   in_valid    operand offered        in_ready  operand can be taken (IDLE)
//   in_mant     unnormalized mantissa  in_exp    its biased exponent
//   out_valid   result offered (DONE)  out_ready downstream takes result
//   out_mant    normalized mantissa    out_exp   adjusted exponent
//   out_zero    input mantissa was zero
//   out_denorm  exponent clamp left the MSB clear on a nonzero mantissa
//
// A single norm_step is reused across cycles: step index s walks the
// stages 16, 8, 4, 2, 1, one per clock. With EARLY_EXIT set the walk stops
// as soon as the MSB is 1; otherwise it always runs all five stages.
module mant_norm_seq
  import fp_norm_pkg::*;
#(
  parameter int MANT_W     = MANT_W_DEF,
  parameter int EXP_W      = EXP_W_DEF,
  parameter int EARLY_EXIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_denorm
);

  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);
  localparam bit         EXIT_EN   = (EARLY_EXIT != 0);

  state_t            state, state_n;
  logic [MANT_W-1:0] cur_mant, cur_mant_n;
  logic [EXP_W-1:0]  cur_exp, cur_exp_n;
  logic [2:0]        s, s_n;

  logic              load_out;
  logic [MANT_W-1:0] ld_mant;
  logic [EXP_W-1:0]  ld_exp;
  logic              ld_zero;

  logic [MANT_W-1:0] step_mant;
  logic [EXP_W-1:0]  step_exp;
  logic              step_took;

  norm_step #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_step (
    .mant         (cur_mant),
    .exp_val      (cur_exp),
    .k            (step_k(s)),
    .shifted_mant (step_mant),
    .shifted_exp  (step_exp),
    .took_shift   (step_took)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Next-state and datapath selection. The output registers are only
  // written on the transition into DONE (load_out), so they hold steady
  // while the result waits for out_ready.
  always_comb begin
    state_n    = state;
    cur_mant_n = cur_mant;
    cur_exp_n  = cur_exp;
    s_n        = s;
    load_out   = 1'b0;
    ld_mant    = cur_mant;
    ld_exp     = cur_exp;
    ld_zero    = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          cur_mant_n = in_mant;
          cur_exp_n  = in_exp;
          s_n        = '0;
          if (in_mant == '0) begin
            state_n  = DONE;
            load_out = 1'b1;
            ld_mant  = '0;
            ld_exp   = '0;
            ld_zero  = 1'b1;
          end else if (EXIT_EN && in_mant[MANT_W-1]) begin
            state_n  = DONE;
            load_out = 1'b1;
            ld_mant  = in_mant;
            ld_exp   = in_exp;
          end else begin
            state_n = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (EXIT_EN && cur_mant[MANT_W-1]) begin
          state_n  = DONE;
          load_out = 1'b1;
        end else begin
          if (step_took) begin
            cur_mant_n = step_mant;
            cur_exp_n  = step_exp;
          end
          if (s == LAST_STEP) begin
            state_n  = DONE;
            load_out = 1'b1;
            ld_mant  = step_mant;
            ld_exp   = step_exp;
          end else begin
            s_n = s + 3'd1;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and result registers; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_mant   <= '0;
      cur_exp    <= '0;
      s          <= '0;
      out_mant   <= '0;
      out_exp    <= '0;
      out_zero   <= 1'b0;
      out_denorm <= 1'b0;
    end else begin
      state    <= state_n;
      cur_mant <= cur_mant_n;
      cur_exp  <= cur_exp_n;
      s        <= s_n;
      if (load_out) begin
        out_mant   <= ld_mant;
        out_exp    <= ld_exp;
        out_zero   <= ld_zero;
        out_denorm <= !ld_zero && !ld_mant[MANT_W-1];
      end
    end
  end

endmodule

// File: tb/tb_mant_norm_seq.sv
// Bench for mant_norm_seq: index 0 is an EARLY_EXIT=1 instance, index 1 an
// EARLY_EXIT=0 instance. Stimulus pushes hand-computed results into a
// per-instance queue; a negedge monitor pops and compares them.
module tb_mant_norm_seq;

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  expo;
    logic        zero;
    logic        denorm;
    int          lat;
    int          acc;
  } entry_t;

  typedef struct {
    int          w;
    logic [23:0] mant;
    logic [7:0]  expo;
    logic [23:0] emant;
    logic [7:0]  eexp;
    logic        ezero;
    logic        edenorm;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [23:0] in_mant    [2];
  logic [7:0]  in_exp     [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [23:0] out_mant   [2];
  logic [7:0]  out_exp    [2];
  logic        out_zero   [2];
  logic        out_denorm [2];

  int checks;
  int errors;
  int cycle;
  int last_acc   [2];
  int xfer_cycle [2];
  bit prev_valid [2];
  bit has_cur    [2];
  bit drop_exp   [2];
  entry_t cur    [2];
  entry_t q_a[$];
  entry_t q_b[$];
  vec_t   vecs[15];

  mant_norm_seq #(.MANT_W(24), .EXP_W(8), .EARLY_EXIT(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_mant(in_mant[0]), .in_exp(in_exp[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_mant(out_mant[0]), .out_exp(out_exp[0]),
    .out_zero(out_zero[0]), .out_denorm(out_denorm[0])
  );

  mant_norm_seq #(.MANT_W(24), .EXP_W(8), .EARLY_EXIT(0)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_mant(in_mant[1]), .in_exp(in_exp[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_mant(out_mant[1]), .out_exp(out_exp[1]),
    .out_zero(out_zero[1]), .out_denorm(out_denorm[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand, wait (bounded) for acceptance, record the
  // acceptance edge and push the expected result.
  task automatic applyStimulus(input int w, input logic [23:0] m, input logic [7:0] e,
                               input logic [23:0] em, input logic [7:0] ee,
                               input logic ez, input logic ed, input int lat);
    entry_t ent;
    int     waited;
    in_mant[w]  = m;
    in_exp[w]   = e;
    in_valid[w] = 1'b1;
    waited = 0;
    while (!in_ready[w] && waited < 60) begin
      tick();
      waited++;
    end
    if (!in_ready[w]) begin
      checkOutput("accept_timeout", 32'(waited), 32'd0);
      in_valid[w] = 1'b0;
      return;
    end
    ent.mant   = em;
    ent.expo   = ee;
    ent.zero   = ez;
    ent.denorm = ed;
    ent.lat    = lat;
    ent.acc    = cycle + 1;
    last_acc[w] = ent.acc;
    if (w == 0) q_a.push_back(ent);
    else        q_b.push_back(ent);
    tick();
    in_valid[w] = 1'b0;
  endtask

  function automatic int qsize(input int w);
    return (w == 0) ? q_a.size() : q_b.size();
  endfunction

  task automatic monitorOne(input int w);
    string tag;
    tag = (w == 0) ? "ee1" : "ee0";
    if (rst) begin
      prev_valid[w] = 1'b0;
      has_cur[w]    = 1'b0;
      drop_exp[w]   = 1'b0;
      return;
    end
    if (drop_exp[w]) begin
      checkOutput({tag, "_valid_drop"}, 32'(out_valid[w]), 32'd0);
      drop_exp[w] = 1'b0;
    end
    if (out_valid[w]) begin
      checkOutput({tag, "_in_ready_busy"}, 32'(in_ready[w]), 32'd0);
      if (!prev_valid[w]) begin
        if (qsize(w) == 0) begin
          checkOutput({tag, "_unexpected_out"}, 32'(out_mant[w]), 32'hFFFF_FFFF);
          has_cur[w] = 1'b0;
        end else begin
          cur[w] = (w == 0) ? q_a.pop_front() : q_b.pop_front();
          has_cur[w] = 1'b1;
          checkOutput({tag, "_latency"}, 32'(cycle - cur[w].acc), 32'(cur[w].lat));
        end
      end
      if (has_cur[w]) begin
        checkOutput({tag, "_mant"},   32'(out_mant[w]),   32'(cur[w].mant));
        checkOutput({tag, "_exp"},    32'(out_exp[w]),    32'(cur[w].expo));
        checkOutput({tag, "_zero"},   32'(out_zero[w]),   32'(cur[w].zero));
        checkOutput({tag, "_denorm"}, 32'(out_denorm[w]), 32'(cur[w].denorm));
      end
      if (out_ready[w]) begin
        drop_exp[w]   = 1'b1;
        xfer_cycle[w] = cycle + 1;
      end
    end
    prev_valid[w] = out_valid[w];
  endtask

  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) monitorOne(w);
  end

  initial begin
    int waited;
    checks = 0;
    errors = 0;
    cycle  = 0;
    rst    = 1'b1;
    for (int w = 0; w < 2; w++) begin
      in_valid[w]  = 1'b0;
      in_mant[w]   = '0;
      in_exp[w]    = '0;
      out_ready[w] = 1'b1;
      prev_valid[w] = 1'b0;
      has_cur[w]    = 1'b0;
      drop_exp[w]   = 1'b0;
      last_acc[w]   = 0;
      xfer_cycle[w] = 0;
    end

    vecs[0]  = '{1, 24'h000001, 8'd100, 24'h800000, 8'd77,  1'b0, 1'b0, 5};
    vecs[1]  = '{0, 24'h000001, 8'd100, 24'h800000, 8'd77,  1'b0, 1'b0, 5};
    vecs[2]  = '{0, 24'h800000, 8'd5,   24'h800000, 8'd5,   1'b0, 1'b0, 0};
    vecs[3]  = '{1, 24'h800000, 8'd5,   24'h800000, 8'd5,   1'b0, 1'b0, 5};
    vecs[4]  = '{0, 24'h000F00, 8'd10,  24'h1E0000, 8'd1,   1'b0, 1'b1, 5};
    vecs[5]  = '{1, 24'h000F00, 8'd10,  24'h1E0000, 8'd1,   1'b0, 1'b1, 5};
    vecs[6]  = '{0, 24'h000000, 8'd50,  24'h000000, 8'd0,   1'b1, 1'b0, 0};
    vecs[7]  = '{1, 24'h000000, 8'd50,  24'h000000, 8'd0,   1'b1, 1'b0, 0};
    vecs[8]  = '{0, 24'h00FFFF, 8'd100, 24'hFFFF00, 8'd92,  1'b0, 1'b0, 3};
    vecs[9]  = '{1, 24'h00FFFF, 8'd100, 24'hFFFF00, 8'd92,  1'b0, 1'b0, 5};
    vecs[10] = '{0, 24'h000123, 8'd0,   24'h000123, 8'd0,   1'b0, 1'b1, 5};
    vecs[11] = '{0, 24'h000001, 8'd24,  24'h800000, 8'd1,   1'b0, 1'b0, 5};
    vecs[12] = '{0, 24'h000001, 8'd23,  24'h400000, 8'd1,   1'b0, 1'b1, 5};
    vecs[13] = '{1, 24'h000001, 8'd255, 24'h800000, 8'd232, 1'b0, 1'b0, 5};
    vecs[14] = '{0, 24'h000010, 8'd1,   24'h000010, 8'd1,   1'b0, 1'b1, 5};

    // Reset state.
    repeat (3) tick();
    for (int w = 0; w < 2; w++) begin
      checkOutput("rst_in_ready",   32'(in_ready[w]),   32'd1);
      checkOutput("rst_out_valid",  32'(out_valid[w]),  32'd0);
      checkOutput("rst_out_mant",   32'(out_mant[w]),   32'd0);
      checkOutput("rst_out_exp",    32'(out_exp[w]),    32'd0);
      checkOutput("rst_out_zero",   32'(out_zero[w]),   32'd0);
      checkOutput("rst_out_denorm", 32'(out_denorm[w]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Directed vectors with downstream always ready.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].w, vecs[i].mant, vecs[i].expo, vecs[i].emant,
                    vecs[i].eexp, vecs[i].ezero, vecs[i].edenorm, vecs[i].lat);
    end

    // Backpressure: result held while out_ready is low, next operand
    // offered throughout and accepted only after the transfer.
    waited = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || out_valid[0] || out_valid[1]) && waited < 200) begin
      tick();
      waited++;
    end
    out_ready[1] = 1'b0;
    applyStimulus(1, 24'h000001, 8'd100, 24'h800000, 8'd77, 1'b0, 1'b0, 5);
    fork
      begin
        int wv;
        wv = 0;
        while (!out_valid[1] && wv < 20) begin
          tick();
          wv++;
        end
        checkOutput("bp_result_seen", 32'(out_valid[1]), 32'd1);
        repeat (3) tick();
        out_ready[1] = 1'b1;
      end
      applyStimulus(1, 24'h000F00, 8'd10, 24'h1E0000, 8'd1, 1'b0, 1'b1, 5);
    join
    checkOutput("bp_accept_after_xfer", 32'(last_acc[1]), 32'(xfer_cycle[1] + 1));

    // Abort: reset while dut_a is in SHIFT at step index 2.
    waited = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || out_valid[0] || out_valid[1]) && waited < 200) begin
      tick();
      waited++;
    end
    applyStimulus(0, 24'h000001, 8'd100, 24'h800000, 8'd77, 1'b0, 1'b0, 5);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_a.delete();
    checkOutput("abort_out_valid",  32'(out_valid[0]),  32'd0);
    checkOutput("abort_in_ready",   32'(in_ready[0]),   32'd1);
    checkOutput("abort_out_mant",   32'(out_mant[0]),   32'd0);
    checkOutput("abort_out_exp",    32'(out_exp[0]),    32'd0);
    checkOutput("abort_out_zero",   32'(out_zero[0]),   32'd0);
    checkOutput("abort_out_denorm", 32'(out_denorm[0]), 32'd0);
    repeat (20) tick();

    // Operation after the abort still works.
    applyStimulus(0, 24'h000F00, 8'd10, 24'h1E0000, 8'd1, 1'b0, 1'b1, 5);
    waited = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || out_valid[0] || out_valid[1]) && waited < 200) begin
      tick();
      waited++;
    end
    checkOutput("drain_queues", 32'(q_a.size() + q_b.size()), 32'd0);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mant_norm_seq.md
Name: mant_norm_seq

Overview:
- Multi-cycle normalization sequencer for the 24-bit mantissa path of the single-precision add/sub unit.
- Takes the raw post-subtract mantissa and its exponent, and left-shifts until bit 23 is set. Shifts run binary-search style, largest stage first, one stage (16, 8, 4, 2, 1) per clock.
- Decrements the exponent by the applied shift and clamps at exponent 1, which gives a denormal result.
- Sits between the mantissa adder and the rounding/packing stage, with valid/ready handshakes on both sides.

Parameters:
- MANT_W, 24, mantissa width including hidden bit. The stage set 16/8/4/2/1 covers MANT_W up to 32.
- EXP_W, 8, biased exponent width.
- EARLY_EXIT, 1, when 1 the sequence ends as soon as the MSB is set; when 0 the latency is fixed.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept an operand.
- in_mant  input  MANT_W  unnormalized mantissa.
- in_exp  input  EXP_W  biased exponent belonging to in_mant.
- out_valid  output  1  normalized result valid.
- out_ready  input  1  downstream accepts the result.
- out_mant  output  MANT_W  normalized mantissa.
- out_exp  output  EXP_W  adjusted exponent.
- out_zero  output  1  input mantissa was zero.
- out_denorm  output  1  result MSB is 0 and out_zero is 0 (exponent clamp hit).

Behaviour:
- Reset and clocking:
  - One clock (clk); reset rst is synchronous and active-high.
  - On reset: state IDLE; out_valid=0, out_mant=0, out_exp=0, out_zero=0, out_denorm=0; in_ready=1 in the cycle after reset.
- States: IDLE, SHIFT, DONE. Registers: cur_mant, cur_exp, and a 3-bit step index s, where s=0..4 selects k=16,8,4,2,1.
- Input side:
  - in_ready = (state==IDLE), combinational from state only.
  - An operand is accepted on an edge where in_valid && in_ready.
- IDLE, on accept edge N, load cur_mant=in_mant, cur_exp=in_exp, s=0, then branch:
  - in_mant==0: go to DONE with out_zero=1, out_mant=0, out_exp=0.
  - EARLY_EXIT=1 and in_mant[MANT_W-1]==1: go to DONE with the value unchanged.
  - Otherwise: go to SHIFT.
- SHIFT, one edge per step, stage k:
  - Shift when the top k bits of cur_mant are all zero AND cur_exp >= k+1. This is an unsigned compare at EXP_W+1 bits, so no wrap.
  - On a shift: cur_mant <<= k (zero fill) and cur_exp -= k. Otherwise hold both.
  - After s=4, go to DONE.
  - EARLY_EXIT=1: if cur_mant MSB is already 1 at the start of a step, go to DONE on that edge with no shift.
  - The greedy stages together apply exactly min(leading_zero_count, in_exp-1) positions. When in_exp<=1, no shift occurs.
- Latency:
  - General path: out_valid is high after edge N+5 (EARLY_EXIT=0 always; EARLY_EXIT=1 worst case).
  - Zero or already-normalized input: out_valid is high after edge N.
- DONE:
  - out_valid=1. The out_* registers are loaded on entry to DONE and held stable while out_valid && !out_ready.
  - out_denorm = !out_zero && !out_mant[MANT_W-1].
  - On an edge with out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
- Occupancy and boundaries:
  - One operation in flight at a time. No input is accepted in SHIFT or DONE; in_valid there is ignored and not latched.
  - Reset mid-operation (SHIFT or DONE) abandons the operation: no output, state IDLE.
  - in_exp==0 with nonzero mantissa: no shift, out_denorm=1 if MSB is 0.

Decomposition:
- Shared package fp_norm_pkg:
  - MANT_W and EXP_W defaults.
  - State encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Stage-size table STEP_K = {16,8,4,2,1} and NUM_STEPS=5.
- One sub-module, norm_step: combinational stage that takes (mant, exp, k) and returns the shifted mant/exp plus a took_shift flag. It is instantiated once and time-shared by the sequencer via s.

Test Plan:
1. in_mant=24'h000001, in_exp=8'd100, EARLY_EXIT=0 -> out_mant=24'h800000, out_exp=8'd77, out_denorm=0; out_valid rises exactly after edge N+5.
2. in_mant=24'h800000, in_exp=8'd5, EARLY_EXIT=1 -> out_valid after edge N; out_mant=24'h800000, out_exp=8'd5.
3. in_mant=24'h000F00, in_exp=8'd10 -> clamped shift of 9: out_mant=24'h1E0000, out_exp=8'd1, out_denorm=1.
4. in_mant=24'h000000, in_exp=8'd50 -> out_zero=1, out_mant=0, out_exp=0, out_valid after edge N.
5. Case 1 with out_ready held low 3 cycles and in_valid held high with a new operand -> outputs stable, in_ready=0, second operand accepted only in the cycle after the result transfer.
6. rst asserted for one edge while in SHIFT at s=2 -> next cycle out_valid=0, in_ready=1, all out_* = 0, no result ever emitted for the aborted operand.
